// File: rtl/alarm_flash_pkg.sv
// Shared types and constants for the flash-request scheduler.
package alarm_flash_pkg;

   typedef enum logic [1:0] {
      StIdle,
      StStart,
      StWait,
      StGap
   } state_e;

   localparam int unsigned ALARM = 0;
   localparam int unsigned CHIME = 1;
   localparam int unsigned CDOWN = 2;

   localparam int unsigned TmrW   = 16;
   localparam int unsigned BurstW = 8;

   // A burst count of zero still produces one flash.
   function automatic logic [BurstW-1:0] rep_sat(input int unsigned rep);
      return (rep == 0) ? BurstW'(1) : BurstW'(rep);
   endfunction

endpackage

// File: rtl/flash_sched_timer.sv
// Loadable down-counter shared by the GAP and WAIT-timeout phases; holds at zero.
module flash_sched_timer
   import alarm_flash_pkg::*;
(
   input  logic            clk,
   input  logic            rst_n,
   input  logic            load,
   input  logic [TmrW-1:0] load_val,
   output logic [TmrW-1:0] value,
   output logic            zero
);

   logic [TmrW-1:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (load) begin
         cnt_d = load_val;
      end else if (cnt_q != '0) begin
         cnt_d = cnt_q - TmrW'(1);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign value = cnt_q;
   assign zero  = (cnt_q == '0);

endmodule

// File: rtl/alarm_flash_sched.sv
// Non-preemptive priority scheduler sharing one LED flasher among three requesters.
module alarm_flash_sched
   import alarm_flash_pkg::*;
#(
   parameter int unsigned REP0    = 3,
   parameter int unsigned REP1    = 1,
   parameter int unsigned REP2    = 2,
   parameter int unsigned GAP_CYC = 16,
   parameter int unsigned TO_CYC  = 4096
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [2:0] req,
   input  logic [2:0] cancel,
   input  logic       flash_done,
   output logic       flash_start,
   output logic [2:0] grant,
   output logic [2:0] pending,
   output logic       busy,
   output logic       timeout_err
);

   localparam logic [TmrW-1:0] ToLoad  = TmrW'(TO_CYC);
   // GAP lasts GAP_CYC cycles: it leaves on the cycle after the counter hits zero.
   localparam logic [TmrW-1:0] GapLoad = (GAP_CYC == 0) ? '0 : TmrW'(GAP_CYC - 1);

   state_e              state_q, state_d;
   logic [2:0]          grant_q, grant_d;
   logic [2:0]          pending_q, pending_d;
   logic [BurstW-1:0]   burst_q, burst_d;
   logic                abort_q, abort_d;
   logic [2:0]          sel, pend_clr;
   logic [BurstW-1:0]   sel_rep;
   logic                owner_cancel;
   logic                tmr_load, tmr_zero;
   logic [TmrW-1:0]     tmr_val, tmr_value;

   flash_sched_timer u_timer (
      .clk      (clk),
      .rst_n    (rst_n),
      .load     (tmr_load),
      .load_val (tmr_val),
      .value    (tmr_value),
      .zero     (tmr_zero)
   );

   always_comb begin
      sel     = '0;
      sel_rep = '0;
      if (pending_q[ALARM]) begin
         sel[ALARM] = 1'b1;
         sel_rep    = rep_sat(REP0);
      end else if (pending_q[CHIME]) begin
         sel[CHIME] = 1'b1;
         sel_rep    = rep_sat(REP1);
      end else if (pending_q[CDOWN]) begin
         sel[CDOWN] = 1'b1;
         sel_rep    = rep_sat(REP2);
      end
   end

   assign owner_cancel = |(cancel & grant_q);

   always_comb begin
      state_d     = state_q;
      grant_d     = grant_q;
      burst_d     = burst_q;
      abort_d     = abort_q;
      pend_clr    = '0;
      tmr_load    = 1'b0;
      tmr_val     = '0;
      timeout_err = 1'b0;
      unique case (state_q)
         StIdle: begin
            if (|pending_q) begin
               pend_clr = sel;
               grant_d  = sel;
               burst_d  = sel_rep;
               abort_d  = 1'b0;
               state_d  = StStart;
            end
         end
         StStart: begin
            if (owner_cancel) begin
               grant_d = '0;
               state_d = StIdle;
            end else begin
               tmr_load = 1'b1;
               tmr_val  = ToLoad;
               state_d  = StWait;
            end
         end
         StWait: begin
            // The flasher cannot be aborted; a cancel here is remembered until flash_done.
            if (owner_cancel) begin
               abort_d = 1'b1;
            end
            if (flash_done) begin
               burst_d = burst_q - BurstW'(1);
               if (abort_q || owner_cancel || burst_q <= BurstW'(1)) begin
                  grant_d = '0;
                  state_d = StIdle;
               end else if (GAP_CYC == 0) begin
                  state_d = StStart;
               end else begin
                  tmr_load = 1'b1;
                  tmr_val  = GapLoad;
                  state_d  = StGap;
               end
            end else if (tmr_value == '0) begin
               timeout_err = 1'b1;
               grant_d     = '0;
               state_d     = StIdle;
            end
         end
         StGap: begin
            if (owner_cancel) begin
               grant_d = '0;
               state_d = StIdle;
            end else if (tmr_zero) begin
               state_d = StStart;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   // Cancel beats a same-cycle request.
   assign pending_d = ((pending_q & ~pend_clr) | req) & ~cancel;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= StIdle;
         grant_q   <= '0;
         pending_q <= '0;
         burst_q   <= '0;
         abort_q   <= 1'b0;
      end else begin
         state_q   <= state_d;
         grant_q   <= grant_d;
         pending_q <= pending_d;
         burst_q   <= burst_d;
         abort_q   <= abort_d;
      end
   end

   assign flash_start = (state_q == StStart);
   assign busy        = (state_q != StIdle);
   assign grant       = grant_q;
   assign pending     = pending_q;

endmodule

// File: tb/tb_alarm_flash_sched.sv
// Directed self-checking bench for alarm_flash_sched with default parameters.
module tb_alarm_flash_sched;

   logic       clk;
   logic       rst_n;
   logic [2:0] req;
   logic [2:0] cancel;
   logic       flash_done;
   logic       flash_start;
   logic [2:0] grant;
   logic [2:0] pending;
   logic       busy;
   logic       timeout_err;

   alarm_flash_sched dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .req         (req),
      .cancel      (cancel),
      .flash_done  (flash_done),
      .flash_start (flash_start),
      .grant       (grant),
      .pending     (pending),
      .busy        (busy),
      .timeout_err (timeout_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_chk  = 0;
   int n_pass = 0;

   // Per-run traces, indexed by cycle relative to the start of the run.
   logic       busy_tr  [0:4199];
   logic [2:0] grant_tr [0:4199];
   logic [2:0] pend_tr  [0:4199];
   int         st_cyc   [0:15];
   logic [2:0] st_gnt   [0:15];
   int         n_st;
   int         n_te;
   int         te_cyc;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      end else begin
         n_pass++;
      end
   endtask

   // Advance one cycle; inputs are single-cycle pulses, sample point is edge+2.
   task automatic tick();
      @(posedge clk);
      #1;
      req        = '0;
      cancel     = '0;
      flash_done = 1'b0;
      #1;
   endtask

   // Flasher model: answers each flash_start with flash_done 10 cycles later when respond=1.
   task automatic run(input int ncyc, input bit respond, input logic [2:0] req0,
                      input int inj_cyc, input logic [2:0] inj_req, input logic [2:0] inj_can);
      int due;
      due    = -1;
      n_st   = 0;
      n_te   = 0;
      te_cyc = -1;
      for (int k = 0; k < ncyc; k++) begin
         busy_tr[k]  = busy;
         grant_tr[k] = grant;
         pend_tr[k]  = pending;
         if (flash_start) begin
            if (n_st < 16) begin
               st_cyc[n_st] = k;
               st_gnt[n_st] = grant;
            end
            n_st++;
            if (respond) due = k + 10;
         end
         if (timeout_err) begin
            te_cyc = k;
            n_te++;
         end
         if (k == due) flash_done = 1'b1;
         if (k == 0) req = req0;
         if (k == inj_cyc) begin
            req    = req | inj_req;
            cancel = inj_can;
         end
         tick();
      end
   endtask

   initial begin
      rst_n      = 1'b0;
      req        = '0;
      cancel     = '0;
      flash_done = 1'b0;
      #12;
      check("reset_outputs", {26'd0, grant, pending}, 32'd0);
      check("reset_flags", {29'd0, busy, flash_start, timeout_err}, 32'd0);
      #11;
      rst_n = 1'b1;
      tick();

      // Single alarm: 3 bursts, start at 2, then done+17 (16 gap cycles in between).
      run(90, 1'b1, 3'b001, -1, 3'b000, 3'b000);
      check("single_pend", {29'd0, pend_tr[1]}, 32'd1);
      check("single_nstart", n_st, 3);
      check("single_s0", st_cyc[0], 2);
      check("single_s1", st_cyc[1], 29);
      check("single_s2", st_cyc[2], 56);
      check("single_grant", {23'd0, st_gnt[0], st_gnt[1], st_gnt[2]}, {23'd0, 9'b001001001});
      check("single_grant_last", {29'd0, grant_tr[66]}, 32'd1);
      check("single_end", {28'd0, busy_tr[67], grant_tr[67]}, 32'd0);

      // Priority: chime (1 burst) then countdown (2 bursts).
      run(80, 1'b1, 3'b110, -1, 3'b000, 3'b000);
      check("prio_pend1", {29'd0, pend_tr[1]}, 32'b110);
      check("prio_pend_svc", {29'd0, pend_tr[5]}, 32'b100);
      check("prio_nstart", n_st, 3);
      check("prio_s0", {st_cyc[0][28:0], st_gnt[0]}, {29'd2, 3'b010});
      check("prio_s1", {st_cyc[1][28:0], st_gnt[1]}, {29'd14, 3'b100});
      check("prio_s2", {st_cyc[2][28:0], st_gnt[2]}, {29'd41, 3'b100});
      check("prio_end", {31'd0, busy_tr[52]}, 32'd0);

      // Non-preemption: alarm request during countdown's first GAP waits its turn.
      run(120, 1'b1, 3'b100, 20, 3'b001, 3'b000);
      check("nopre_pend", {29'd0, pend_tr[21]}, 32'b001);
      check("nopre_grant_gap", {29'd0, grant_tr[25]}, 32'b100);
      check("nopre_nstart", n_st, 5);
      check("nopre_s1", {st_cyc[1][28:0], st_gnt[1]}, {29'd29, 3'b100});
      check("nopre_s2", {st_cyc[2][28:0], st_gnt[2]}, {29'd41, 3'b001});
      check("nopre_s4", {st_cyc[4][28:0], st_gnt[4]}, {29'd95, 3'b001});

      // Cancel in GAP: idle next cycle, no more flashes.
      run(80, 1'b1, 3'b001, 20, 3'b000, 3'b001);
      check("can_gap_before", {31'd0, busy_tr[20]}, 32'd1);
      check("can_gap_after", {28'd0, busy_tr[21], grant_tr[21]}, 32'd0);
      check("can_gap_nstart", n_st, 1);

      // Cancel in WAIT: completes the running flash, then idle.
      run(60, 1'b1, 3'b001, 5, 3'b000, 3'b001);
      check("can_wait_busy", {31'd0, busy_tr[12]}, 32'd1);
      check("can_wait_idle", {28'd0, busy_tr[13], grant_tr[13]}, 32'd0);
      check("can_wait_nstart", n_st, 1);

      // Request and cancel in the same cycle.
      run(10, 1'b1, 3'b001, 0, 3'b000, 3'b001);
      check("req_can_pend", {29'd0, pend_tr[1]}, 32'd0);
      check("req_can_busy", {31'd0, busy_tr[2]}, 32'd0);
      check("req_can_nstart", n_st, 0);

      // Timeout: flash_done withheld; WAIT entered after cycle 2, fires 4096 cycles later.
      run(4110, 1'b0, 3'b001, -1, 3'b000, 3'b000);
      check("to_count", n_te, 1);
      check("to_cycle", te_cyc, 4099);
      check("to_grant_before", {29'd0, grant_tr[4099]}, 32'b001);
      check("to_after", {28'd0, busy_tr[4100], grant_tr[4100]}, 32'd0);

      // Asynchronous reset mid-GAP with another request pending.
      run(20, 1'b1, 3'b001, 15, 3'b010, 3'b000);
      check("rst_pre_state", {28'd0, busy, pending}, {28'd0, 4'b1010});
      #1;
      rst_n = 1'b0;
      #1;
      check("rst_async_out", {26'd0, grant, pending}, 32'd0);
      check("rst_async_flags", {29'd0, busy, flash_start, timeout_err}, 32'd0);
      tick();
      tick();
      #1;
      rst_n = 1'b1;
      run(70, 1'b1, 3'b100, -1, 3'b000, 3'b000);
      check("post_rst_nstart", n_st, 2);
      check("post_rst_s0", {st_cyc[0][28:0], st_gnt[0]}, {29'd2, 3'b100});

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
